// File: rtl/mac_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mac_seq_ctrl
// Sequences one dot-product job on a MAC accumulator (or a lockstep bank of
// lanes). Each job runs FLUSH -> CLEAR -> RUN -> DRAIN -> DONE:
//   FLUSH : one enabled beat with zeroed operands empties the product register
//   CLEAR : clears the accumulator (including anything FLUSH added to it)
//   RUN   : streams len operand beats under a valid/ready handshake
//   DRAIN : one enabled beat with zeroed operands folds the last product in
//   DONE  : one-cycle done pulse; Cout is final
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   start, len    : job request (IDLE only), beats in the job
//   abort         : cancel the job in flight
//   op_valid      : operand source presents a beat
//   op_ready      : controller takes a beat (RUN only)
//   mac_en        : MAC En input
//   mac_clr       : MAC Clr input
//   zero_ops      : forces the MAC operand muxes to zero
//   busy          : not IDLE
//   done          : one-cycle completion pulse
//   result_valid  : Cout holds a completed result
//   timeout_err   : sticky stall-timeout flag
//   beat_cnt      : beats accepted in the current or last job
// ---------------------------------------------------------------------------
module mac_seq_ctrl #(
   parameter int LEN_WIDTH   = 8,
   parameter int STALL_WIDTH = 8,
   parameter int STALL_LIMIT = 100
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LEN_WIDTH-1:0] len,
   input  logic                 abort,
   input  logic                 op_valid,
   output logic                 op_ready,
   output logic                 mac_en,
   output logic                 mac_clr,
   output logic                 zero_ops,
   output logic                 busy,
   output logic                 done,
   output logic                 result_valid,
   output logic                 timeout_err,
   output logic [LEN_WIDTH-1:0] beat_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FLUSH = 3'd1,
      ST_CLEAR = 3'd2,
      ST_RUN   = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam logic [LEN_WIDTH-1:0]   LEN_ZERO    = LEN_WIDTH'(0);
   localparam logic [LEN_WIDTH-1:0]   LEN_ONE     = LEN_WIDTH'(1);
   localparam logic [STALL_WIDTH-1:0] STALL_ZERO  = STALL_WIDTH'(0);
   localparam logic [STALL_WIDTH-1:0] STALL_ONE   = STALL_WIDTH'(1);
   localparam logic [STALL_WIDTH-1:0] STALL_MAX   = {STALL_WIDTH{1'b1}};
   localparam logic [STALL_WIDTH-1:0] STALL_LIM_C = STALL_WIDTH'(STALL_LIMIT);
   localparam logic                   TIMEOUT_EN  = (STALL_LIMIT != 0);

   state_t                 state_r, state_s;
   logic [LEN_WIDTH-1:0]   len_r;
   logic [LEN_WIDTH-1:0]   beat_cnt_r;
   logic [STALL_WIDTH-1:0] stall_r;
   logic [STALL_WIDTH-1:0] stall_nxt_s;
   logic                   result_valid_r;
   logic                   timeout_err_r;
   logic                   job_start_s;
   logic                   beat_acc_s;
   logic                   stall_inc_s;
   logic                   timeout_s;

   // Saturating increment of the stall counter.
   assign stall_nxt_s = (stall_r == STALL_MAX) ? stall_r : (stall_r + STALL_ONE);

   // Next-state logic and per-cycle event strobes for the register block.
   always_comb begin
      state_s     = state_r;
      job_start_s = 1'b0;
      beat_acc_s  = 1'b0;
      stall_inc_s = 1'b0;
      timeout_s   = 1'b0;
      if (abort && (state_r != ST_IDLE)) begin
         // abort outranks completion and timeout; the beat is not counted
         state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start && !abort) begin
                  state_s     = ST_FLUSH;
                  job_start_s = 1'b1;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_FLUSH: state_s = ST_CLEAR;
            ST_CLEAR: state_s = (len_r != LEN_ZERO) ? ST_RUN : ST_DRAIN;
            ST_RUN: begin
               if (op_valid) begin
                  beat_acc_s = 1'b1;
                  state_s    = ((beat_cnt_r + LEN_ONE) == len_r) ? ST_DRAIN : ST_RUN;
               end else begin
                  stall_inc_s = 1'b1;
                  if (TIMEOUT_EN && (stall_nxt_s >= STALL_LIM_C)) begin
                     timeout_s = 1'b1;
                     state_s   = ST_IDLE;
                  end else begin
                     state_s = ST_RUN;
                  end
               end
            end
            ST_DRAIN: state_s = ST_DONE;
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
         endcase
      end
   end

   // State, job length, counters and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         len_r          <= LEN_ZERO;
         beat_cnt_r     <= LEN_ZERO;
         stall_r        <= STALL_ZERO;
         result_valid_r <= 1'b0;
         timeout_err_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         if (job_start_s) begin
            len_r          <= len;
            beat_cnt_r     <= LEN_ZERO;
            stall_r        <= STALL_ZERO;
            result_valid_r <= 1'b0;
            timeout_err_r  <= 1'b0;
         end else begin
            if (beat_acc_s) begin
               beat_cnt_r <= beat_cnt_r + LEN_ONE;
               stall_r    <= STALL_ZERO;
            end else if (stall_inc_s) begin
               stall_r <= stall_nxt_s;
            end
            if (timeout_s) begin
               timeout_err_r <= 1'b1;
            end
            // result becomes valid as DONE is entered, so it is already set
            // in the done cycle
            if (abort) begin
               result_valid_r <= 1'b0;
            end else if (state_r == ST_DRAIN) begin
               result_valid_r <= 1'b1;
            end
         end
      end
   end

   // Moore strobes decoded from the state; mac_en follows op_valid in RUN.
   always_comb begin
      op_ready = 1'b0;
      mac_en   = 1'b0;
      mac_clr  = 1'b0;
      zero_ops = 1'b0;
      done     = 1'b0;
      case (state_r)
         ST_FLUSH: begin
            mac_en   = 1'b1;
            zero_ops = 1'b1;
         end
         ST_CLEAR: mac_clr = 1'b1;
         ST_RUN: begin
            op_ready = 1'b1;
            mac_en   = op_valid;
         end
         ST_DRAIN: begin
            mac_en   = 1'b1;
            zero_ops = 1'b1;
         end
         ST_DONE:  done = 1'b1;
         default: begin
            op_ready = 1'b0;
         end
      endcase
   end

   assign busy         = (state_r != ST_IDLE);
   assign result_valid = result_valid_r;
   assign timeout_err  = timeout_err_r;
   assign beat_cnt     = beat_cnt_r;

endmodule
